// File: rtl/startup_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : startup_seq_pkg
//  Purpose  : Shared types and elaboration helpers for the startup sequencer.
//             - startup_state_t : sequencer state encoding
//             - cnt_width_ok()  : checks that a delay counter of a given width
//                                 can hold (max_val - 1)
//  Revision : 1.0 - initial release
// ============================================================================
package startup_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        UP   = 3'd2,
        ON   = 3'd3,
        DOWN = 3'd4
    } startup_state_t;

    // A counter loaded with (max_val - 1) needs clog2(max_val) bits.
    function automatic bit cnt_width_ok(input int max_val, input int width);
        return ($clog2(max_val) <= width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/startup_dly_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : startup_dly_cnt
//  Purpose  : Loadable down-counter that parks at zero.
//  Ports    : clk_i      - clock
//             rst_n_i    - synchronous active-low reset (counter -> 0)
//             load_i     - load load_val_i this cycle (wins over decrement)
//             load_val_i - value to load
//             expire_o   - counter is zero
//  Revision : 1.0 - initial release
// ============================================================================
module startup_dly_cnt #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic                 expire_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/startup_seq.sv
`default_nettype none
// ============================================================================
//  Module   : startup_seq
//  Purpose  : Power/clock-gate startup sequencer for CH_NUM channels. Raises
//             gates in ascending order after an initial delay while en_i=1,
//             lowers them in reverse order while en_i=0; abort and re-entry
//             are allowed at any point.
//  Ports    : clk_i     - clock
//             rst_n_i   - synchronous active-low reset
//             en_i      - 1 = sequence up / hold, 0 = sequence down
//             gate_en_o - registered channel gate enables
//             done_o    - all channels on and holding
//             busy_o    - sequence in progress
//             ack_i     - per-channel ready      (STARTUP_SEQ_ACK_EN only)
//             fault_o   - sticky ack timeout     (STARTUP_SEQ_ACK_EN only)
//  Config   : define STARTUP_SEQ_ACK_EN to gate each step on the ack of the
//             most recently raised channel, with an ACK_TMO timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module startup_seq
    import startup_seq_pkg::*;
#(
    parameter int CH_NUM    = 5,
    parameter int INIT_DLY  = 1000,
    parameter int STEP_DLY  = 1000,
    parameter int CNT_WIDTH = 24,
    parameter int ACK_TMO   = 4096
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
`ifdef STARTUP_SEQ_ACK_EN
    input  logic [CH_NUM-1:0] ack_i,
    output logic              fault_o,
`endif
    output logic [CH_NUM-1:0] gate_en_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int MAX_A   = (INIT_DLY > STEP_DLY) ? INIT_DLY : STEP_DLY;
    localparam int MAX_DLY = (MAX_A > ACK_TMO) ? MAX_A : ACK_TMO;

    localparam logic [CNT_WIDTH-1:0] INIT_LD  = CNT_WIDTH'(INIT_DLY - 1);
    localparam logic [CNT_WIDTH-1:0] STEP_LD  = CNT_WIDTH'(STEP_DLY - 1);
    localparam logic [CH_NUM-1:0]    GATE_LSB = CH_NUM'(1);

    if (CH_NUM < 1 || INIT_DLY < 1 || STEP_DLY < 1 ||
        !cnt_width_ok(MAX_DLY, CNT_WIDTH)) begin : g_param_err
        $error("startup_seq: illegal parameter set");
    end

    startup_state_t       state_q, state_d;
    // Gates are always a thermometer mask from bit 0 upwards, so the mask
    // itself doubles as the channel index.
    logic [CH_NUM-1:0]    gate_en_q, gate_en_d;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_val;
    logic                 cnt_exp;
    logic                 step_go;
    logic                 start_req;
    logic                 up_req;

    startup_dly_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_step_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .expire_o   (cnt_exp)
    );

`ifdef STARTUP_SEQ_ACK_EN
    localparam logic [CNT_WIDTH-1:0] TMO_LD = CNT_WIDTH'(ACK_TMO - 1);

    logic fault_q, fault_d;
    logic armed_q, armed_d;
    logic tmo_load, tmo_exp;
    logic ack_top;
    logic tmo_hit;

    // Highest raised gate is the only bit where the mask differs from its
    // own right shift.
    assign ack_top   = |(ack_i & gate_en_q & ~(gate_en_q >> 1));
    assign step_go   = cnt_exp & ack_top;
    assign tmo_hit   = tmo_exp & ~ack_top;
    // After a fault a fresh 0 -> 1 on en_i is needed before restarting.
    assign start_req = en_i & armed_q;
    // A fault-driven ramp down runs to completion regardless of en_i.
    assign up_req    = en_i & ~fault_q;

    startup_dly_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_tmo_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmo_load),
        .load_val_i (TMO_LD),
        .expire_o   (tmo_exp)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fault_q <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            fault_q <= fault_d;
            armed_q <= armed_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign step_go   = cnt_exp;
    assign start_req = en_i;
    assign up_req    = en_i;
`endif

    always_comb begin
        state_d   = state_q;
        gate_en_d = gate_en_q;
        cnt_load  = 1'b0;
        cnt_val   = STEP_LD;
`ifdef STARTUP_SEQ_ACK_EN
        fault_d   = fault_q;
        armed_d   = armed_q | ~en_i;
        tmo_load  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d  = INIT;
                    cnt_load = 1'b1;
                    cnt_val  = INIT_LD;
`ifdef STARTUP_SEQ_ACK_EN
                    fault_d  = 1'b0;
`endif
                end
            end
            INIT: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (cnt_exp) begin
                    gate_en_d = GATE_LSB;
                    cnt_load  = 1'b1;
                    state_d   = (CH_NUM == 1) ? ON : UP;
`ifdef STARTUP_SEQ_ACK_EN
                    tmo_load  = 1'b1;
`endif
                end
            end
            UP: begin
`ifdef STARTUP_SEQ_ACK_EN
                if (tmo_hit) begin
                    state_d  = DOWN;
                    cnt_load = 1'b1;
                    fault_d  = 1'b1;
                    armed_d  = 1'b0;
                end else
`endif
                if (!en_i) begin
                    state_d  = DOWN;
                    cnt_load = 1'b1;
                end else if (step_go) begin
                    gate_en_d = (gate_en_q << 1) | GATE_LSB;
                    cnt_load  = 1'b1;
`ifdef STARTUP_SEQ_ACK_EN
                    tmo_load  = 1'b1;
`endif
                    if (gate_en_d[CH_NUM-1]) begin
                        state_d = ON;
                    end
                end
            end
            ON: begin
                if (!en_i) begin
                    state_d  = DOWN;
                    cnt_load = 1'b1;
                end
            end
            DOWN: begin
                if (up_req) begin
                    // Re-entry before any gate dropped goes straight back to ON.
                    if (gate_en_q[CH_NUM-1]) begin
                        state_d = ON;
                    end else begin
                        state_d  = UP;
                        cnt_load = 1'b1;
`ifdef STARTUP_SEQ_ACK_EN
                        tmo_load = 1'b1;
`endif
                    end
                end else if (cnt_exp) begin
                    gate_en_d = gate_en_q >> 1;
                    cnt_load  = 1'b1;
                    if (gate_en_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gate_en_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gate_en_q <= '0;
        end else begin
            state_q   <= state_d;
            gate_en_q <= gate_en_d;
        end
    end

    assign gate_en_o = gate_en_q;
    assign done_o    = (state_q == ON);
    assign busy_o    = (state_q == INIT) || (state_q == UP) || (state_q == DOWN);

endmodule
`default_nettype wire
